serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_subtractor_fullsubtractor.sv | 26 ++
 rtl/serial_subtractor.sv | 131 +++++++++++++
 tb/tb_serial_subtractor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor:
//     - DEFAULT_WIDTH : default operand/result width in bits
//     - state_t       : controller state encoding (IDLE, RUN, DONE)
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_fullsubtractor.sv
// ---------------------------------------------------------------------------
// fullsubtractor
//   One-bit combinational subtract cell: computes a - b - bin.
//   Ports:
//     a    in  1  minuend bit
//     b    in  1  subtrahend bit
//     bin  in  1  borrow from the less significant bit
//     d    out 1  difference bit
//     bout out 1  borrow into the next more significant bit
// ---------------------------------------------------------------------------
module fullsubtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // A borrow is produced when b alone exceeds a, or when a and b are
    // equal and a borrow is already pending from below.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule : fullsubtractor

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor computing {bout,diff} = a - b - bin, one bit per
//   clock, LSB first.
//   Ports:
//     clk   in  1      clock, rising edge active
//     rst_n in  1      asynchronous active-low reset
//     start in  1      request, only sampled while idle
//     a     in  WIDTH  minuend, captured on the accepting edge
//     b     in  WIDTH  subtrahend, captured on the accepting edge
//     bin   in  1      borrow-in, captured on the accepting edge
//     busy  out 1      high while bits are being processed
//     done  out 1      one-cycle pulse marking diff/bout valid
//     diff  out WIDTH  registered difference
//     bout  out 1      registered borrow-out
// ---------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             load;
    logic             shift;
    logic             last_bit;
    logic             cell_d;
    logic             cell_bout;

    // The single subtract cell always looks at the current LSBs of the
    // operand shift registers and the pending borrow.
    fullsubtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and datapath controls. A new request is only looked
    // at in IDLE, so start during RUN/DONE has no effect. DONE always falls
    // back to IDLE, which makes back-to-back operations 10 cycles apart at
    // WIDTH=8.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        last_bit   = (cnt == LAST_BIT);
        busy       = (state == RUN);
        done       = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. Difference bits enter from the MSB end so that after WIDTH
    // shifts bit 0 of the result sits at diff[0]. The counter stops at
    // WIDTH-1 instead of wrapping; the next load clears it. diff and bout
    // are only rewritten by RUN, so they hold the last result while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else if (load) begin
            a_sr <= a;
            b_sr <= b;
            br   <= bin;
            cnt  <= '0;
        end else if (shift) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            br   <= cell_bout;
            diff <= {cell_d, diff[WIDTH-1:1]};
            if (last_bit) begin
                bout <= cell_bout;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor at WIDTH=8. Expected results
//   are pushed to a scoreboard queue when an operation is launched and
//   popped by a monitor whenever the DUT pulses done.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    int               totalChecks = 0;
    int               badChecks = 0;
    int               doneCount = 0;
    int               cyc = 0;
    logic [WIDTH:0]   scoreboard[$];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference: 9-bit two's-complement result of a - b - bin.
    function automatic logic [WIDTH:0] refModel(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             c);
        return {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, c};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     tag, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest pending
    // expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            doneCount++;
            if (scoreboard.size() == 0) begin
                checkOutput("spurious_done", 32'd1, 32'd0);
            end else begin
                logic [WIDTH:0] exp;
                exp = scoreboard.pop_front();
                checkOutput("result", 32'({bout, diff}), 32'(exp));
            end
        end
    end

    // Launch one operation, optionally pulse a stray start during RUN
    // cycle `disturb` (0 = none), wait for done and check busy length,
    // the single done pulse and that the result is held afterwards.
    task automatic applyStimulus(input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv,
                                 input logic             cv,
                                 input int               disturb);
        int             n;
        int             busyCycles;
        int             doneBefore;
        logic [WIDTH:0] exp;
        exp        = refModel(av, bv, cv);
        doneBefore = doneCount;
        @(negedge clk);
        a     = av;
        b     = bv;
        bin   = cv;
        start = 1'b1;
        scoreboard.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        a     = 8'hA5;
        b     = 8'h5A;
        bin   = 1'b1;
        n          = 0;
        busyCycles = 0;
        while (!done && n < 40) begin
            if (busy) busyCycles++;
            if (disturb > 0 && n == disturb - 1) begin
                start = 1'b1;
                a     = 8'h10;
                b     = 8'h01;
                bin   = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (n >= 40) checkOutput("done_timeout", 32'd0, 32'd1);
        checkOutput("busy_cycles", 32'(busyCycles), 32'(WIDTH));
        @(negedge clk);
        checkOutput("done_count", 32'(doneCount - doneBefore), 32'd1);
        checkOutput("idle_after", 32'({busy, done}), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("hold", 32'({bout, diff}), 32'(exp));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int             doneBefore;
        int             lastDone;
        logic [WIDTH:0] exp;

        // Reset state.
        #3;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_diff", 32'(diff), 32'd0);
        checkOutput("rst_bout", 32'(bout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        applyStimulus(8'h35, 8'h12, 1'b0, 0);
        applyStimulus(8'h00, 8'h01, 1'b0, 0);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 0);
        applyStimulus(8'h80, 8'h7F, 1'b1, 3);

        // Abort mid-RUN with reset.
        doneBefore = doneCount;
        @(negedge clk);
        a     = 8'h55;
        b     = 8'h22;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_abort_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_diff", 32'(diff), 32'd0);
        checkOutput("abort_bout", 32'(bout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("abort_no_done", 32'(doneCount - doneBefore), 32'd0);
        applyStimulus(8'h09, 8'h04, 1'b0, 0);

        // Back-to-back with start held high: operands for the next run are
        // set while done is high; acceptance follows two edges later.
        @(negedge clk);
        a     = 8'($urandom_range(0, 255));
        b     = 8'($urandom_range(0, 255));
        bin   = 1'($urandom_range(0, 1));
        start = 1'b1;
        scoreboard.push_back(refModel(a, b, bin));
        lastDone = 0;
        for (int k = 0; k < 5; k++) begin
            int n;
            n = 0;
            @(negedge clk);
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) checkOutput("b2b_timeout", 32'd0, 32'd1);
            if (k > 0) checkOutput("b2b_period", 32'(cyc - lastDone), 32'd10);
            lastDone = cyc;
            if (k < 4) begin
                a   = 8'($urandom_range(0, 255));
                b   = 8'($urandom_range(0, 255));
                bin = 1'($urandom_range(0, 1));
                scoreboard.push_back(refModel(a, b, bin));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            checkOutput("b2b_idle", 32'({busy, done}), 32'd0);
        end
        repeat (3) @(negedge clk);

        // Random regression.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)), 0);
        end

        checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
        exp = refModel(8'h00, 8'h00, 1'b1);
        checkOutput("model_sanity", 32'(exp), 32'h1FF);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule : tb_serial_subtractor
